mac_half_dot_driver: RTL



---
 rtl/mac_half_dot_driver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mac_half_dot_driver.sv
// Drives an external fixed-latency FP16 MAC. It folds a handshaked stream of operand pairs
// into an FP32 dot product per s_last-terminated vector and returns it on a valid/ready port.
module mac_half_dot_driver #(
  parameter int unsigned MAC_LATENCY = 4,
  parameter logic [31:0] INIT_ACC    = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_a,
  input  logic [15:0] s_b,
  input  logic        s_last,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic [31:0] mac_c,
  input  logic [31:0] mac_q,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_result,
  output logic [15:0] o_count
);

  localparam int unsigned LAT_W = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned OP_W  = 16;
  localparam int unsigned ACC_W = 32;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_WAIT   = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  state_t             r_state,    w_state;
  logic               r_s_ready,  w_s_ready;
  logic [OP_W-1:0]    r_mac_a,    w_mac_a;
  logic [OP_W-1:0]    r_mac_b,    w_mac_b;
  logic [ACC_W-1:0]   r_mac_c,    w_mac_c;
  logic [ACC_W-1:0]   r_acc,      w_acc;
  logic [CNT_W-1:0]   r_elem_cnt, w_elem_cnt;
  logic [LAT_W-1:0]   r_lat_cnt,  w_lat_cnt;
  logic               r_last,     w_last;
  logic               r_o_valid,  w_o_valid;
  logic [ACC_W-1:0]   r_o_result, w_o_result;
  logic [CNT_W-1:0]   r_o_count,  w_o_count;

  logic               w_accept;
  logic               w_mac_done;
  logic [CNT_W-1:0]   w_elem_inc;

  assign w_accept   = (r_state == ST_ACCEPT) && r_s_ready && s_valid;
  assign w_mac_done = (r_lat_cnt == LAT_W'(MAC_LATENCY));
  assign w_elem_inc = (r_elem_cnt == {CNT_W{1'b1}}) ? r_elem_cnt : r_elem_cnt + CNT_W'(1);

  // Next-state and next-register logic
  always_comb begin
    w_state    = r_state;
    w_mac_a    = r_mac_a;
    w_mac_b    = r_mac_b;
    w_mac_c    = r_mac_c;
    w_acc      = r_acc;
    w_elem_cnt = r_elem_cnt;
    w_lat_cnt  = r_lat_cnt;
    w_last     = r_last;
    w_o_valid  = r_o_valid;
    w_o_result = r_o_result;
    w_o_count  = r_o_count;

    case (r_state)
      ST_ACCEPT: begin
        w_mac_c = r_acc;
        if (w_accept) begin
          w_mac_a   = s_a;
          w_mac_b   = s_b;
          w_last    = s_last;
          w_lat_cnt = '0;
          w_state   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_mac_done) begin
          w_mac_a = '0;
          w_mac_b = '0;
          if (r_last) begin
            w_o_result = mac_q;
            w_o_count  = w_elem_inc;
            w_o_valid  = 1'b1;
            w_acc      = INIT_ACC;
            w_elem_cnt = '0;
            w_mac_c    = INIT_ACC;
            w_state    = ST_OUT;
          end else begin
            w_acc      = mac_q;
            w_elem_cnt = w_elem_inc;
            w_mac_c    = mac_q;
            w_state    = ST_ACCEPT;
          end
        end else begin
          w_lat_cnt = r_lat_cnt + LAT_W'(1);
        end
      end
      ST_OUT: begin
        if (r_o_valid && o_ready) begin
          w_o_valid = 1'b0;
          w_state   = ST_ACCEPT;
        end
      end
      default: w_state = ST_ACCEPT;
    endcase

    // Registered ready derived from next state, so o_ready never reaches s_ready combinationally
    w_s_ready = (w_state == ST_ACCEPT);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_ACCEPT;
      r_s_ready  <= 1'b0;
      r_mac_a    <= '0;
      r_mac_b    <= '0;
      r_mac_c    <= INIT_ACC;
      r_acc      <= INIT_ACC;
      r_elem_cnt <= '0;
      r_lat_cnt  <= '0;
      r_last     <= 1'b0;
      r_o_valid  <= 1'b0;
      r_o_result <= '0;
      r_o_count  <= '0;
    end else begin
      r_state    <= w_state;
      r_s_ready  <= w_s_ready;
      r_mac_a    <= w_mac_a;
      r_mac_b    <= w_mac_b;
      r_mac_c    <= w_mac_c;
      r_acc      <= w_acc;
      r_elem_cnt <= w_elem_cnt;
      r_lat_cnt  <= w_lat_cnt;
      r_last     <= w_last;
      r_o_valid  <= w_o_valid;
      r_o_result <= w_o_result;
      r_o_count  <= w_o_count;
    end
  end

  assign s_ready  = r_s_ready;
  assign mac_a    = r_mac_a;
  assign mac_b    = r_mac_b;
  assign mac_c    = r_mac_c;
  assign o_valid  = r_o_valid;
  assign o_result = r_o_result;
  assign o_count  = r_o_count;

endmodule
